// File: rtl/trap_pkg.sv
// Shared types and cause constants for the commit-stage trap controller.
package trap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRAP,
        S_TGT,
        S_RET,
        S_REDIR
    } state_e;

    localparam logic [62:0] CAUSE_MISALIGN = 63'd0;
    localparam logic [62:0] CAUSE_ILLEGAL  = 63'd2;
    localparam logic [62:0] CAUSE_EBREAK   = 63'd3;
    localparam logic [62:0] CAUSE_ECALL    = 63'd11;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder from commit-stage trap flags to an exception cause code.
module trap_cause_enc
    import trap_pkg::*;
(
    input  logic        misalign_i,
    input  logic        illegal_i,
    input  logic        ebreak_i,
    input  logic        ecall_i,
    output logic        hit_o,
    output logic [62:0] code_o
);

    always_comb begin
        hit_o  = 1'b1;
        code_o = '0;
        case (1'b1)
            misalign_i: code_o = CAUSE_MISALIGN;
            illegal_i:  code_o = CAUSE_ILLEGAL;
            ebreak_i:   code_o = CAUSE_EBREAK;
            ecall_i:    code_o = CAUSE_ECALL;
            default: begin
                hit_o  = 1'b0;
                code_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: raises the CSR trap or mret strobe, then
// steers the pipeline to the new PC while holding the commit stage.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [63:0] wb_pc,
    input  logic        wb_inst_misalign,
    input  logic        wb_illegal,
    input  logic        wb_ebreak,
    input  logic        wb_ecall,
    input  logic        wb_mret,
    output logic        wb_ready,
    output logic        ex,
    output logic        ex_ret,
    output logic [63:0] epc,
    output logic [62:0] ecode,
    input  logic [63:0] ex_entry,
    input  logic [63:0] csr_rvalue,
    output logic        flush,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready
);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [62:0] cause_q, cause_d;
    logic [63:0] tgt_q, tgt_d;

    logic        enc_hit;
    logic [62:0] enc_code;
    logic        trap_req;

    trap_cause_enc u_enc (
        .misalign_i (wb_inst_misalign),
        .illegal_i  (wb_illegal),
        .ebreak_i   (wb_ebreak),
        .ecall_i    (wb_ecall),
        .hit_o      (enc_hit),
        .code_o     (enc_code)
    );

    assign trap_req = wb_valid & enc_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            tgt_q   <= tgt_d;
        end
    end

    // ex_entry is only valid once the CSR has absorbed the trap, hence TGT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cause_d = cause_q;
        tgt_d   = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (trap_req) begin
                    pc_d    = wb_pc;
                    cause_d = enc_code;
                    state_d = S_TRAP;
                end else if (wb_valid && wb_mret) begin
                    state_d = S_RET;
                end
            end
            S_TRAP: state_d = S_TGT;
            S_TGT: begin
                tgt_d   = ex_entry;
                state_d = S_REDIR;
            end
            S_RET: begin
                tgt_d   = csr_rvalue;
                state_d = S_REDIR;
            end
            S_REDIR: begin
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wb_ready       = (state_q == S_IDLE);
    assign flush          = (state_q != S_IDLE);
    assign ex             = (state_q == S_TRAP);
    assign ex_ret         = (state_q == S_RET);
    assign epc            = ex ? pc_q : '0;
    assign ecode          = ex ? cause_q : '0;
    assign redirect_valid = (state_q == S_REDIR);
    assign redirect_pc    = redirect_valid ? tgt_q : '0;

endmodule
